// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller:
//   - state_e      : controller state (RUN, HOLD)
//   - F3_*         : RV32I conditional-branch funct3 encodings
//   - stall_len()  : required stall length N for the events seen in ID
// -----------------------------------------------------------------------------
package hazard_pkg;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HOLD = 1'b1
   } state_e;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Stall length for the current ID-stage events. A load-use hazard needs
   // load_lat cycles; a branch operand needs one cycle from an ALU producer
   // and one more than the load latency from a load producer, since the
   // branch resolves in ID rather than EX. When both apply the longer wins.
   function automatic int unsigned stall_len(
      input logic        load_ev,
      input logic        br_ev,
      input logic        mem_read,
      input int unsigned load_lat
   );
      int unsigned n_load;
      int unsigned n_br;
      n_load = load_ev ? load_lat : 0;
      n_br   = br_ev ? (mem_read ? load_lat + 1 : 1) : 0;
      return (n_load > n_br) ? n_load : n_br;
   endfunction

endpackage

// File: rtl/branch_cmp.sv
// -----------------------------------------------------------------------------
// branch_cmp
// Combinational RV32I branch condition evaluator.
// Ports:
//   rs1_data, rs2_data : in  XLEN  branch operands
//   funct3             : in  3     branch condition select
//   taken              : out 1     condition holds (reserved encodings -> 0)
// -----------------------------------------------------------------------------
module branch_cmp
   import hazard_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [2:0]      funct3,
   output logic            taken
);

   // NOTE: every signal written in always_comb gets a default first, so no
   // path through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      taken = 1'b0;
      case (funct3)
         F3_BEQ:  taken = (rs1_data == rs2_data);
         F3_BNE:  taken = (rs1_data != rs2_data);
         F3_BLT:  taken = ($signed(rs1_data) <  $signed(rs2_data));
         F3_BGE:  taken = ($signed(rs1_data) >= $signed(rs2_data));
         F3_BLTU: taken = (rs1_data <  rs2_data);
         F3_BGEU: taken = (rs1_data >= rs2_data);
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard controller between the IF/ID and ID/EX pipeline registers.
// Detects load-use and branch-operand hazards, holds the stall for N cycles
// with a down-counter, freezes the pipeline while data memory is busy and
// resolves branches in ID to generate the IF/ID flush.
//
// Optional feature: define HAZARD_PERF_CNT_EN to add the saturating 32-bit
// performance counters stall_cnt_o and flush_cnt_o.
//
// Ports:
//   clk_i, rst_i                   : clock, synchronous active-high reset
//   ID_EX_MemRead_i                : EX instruction is a load
//   ID_EX_RegWrite_i               : EX instruction writes rd
//   ID_EX_RegisterRd_i             : EX destination register
//   IF_ID_RS1_i, IF_ID_RS2_i       : ID source registers
//   Registers_RS1data_i/RS2data_i  : ID operands
//   branch_i, funct3_i             : ID conditional branch and its condition
//   mem_stall_i                    : data memory busy
//   stall_o                        : hold IF/ID, bubble into ID/EX
//   PCWrite_o                      : PC update enable
//   freeze_o                       : hold every pipeline register
//   flush_o                        : branch taken, flush IF/ID
//   stall_cnt_o, flush_cnt_o       : perf counters (HAZARD_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned CNT_W    = 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ID_EX_MemRead_i,
   input  logic              ID_EX_RegWrite_i,
   input  logic [REG_AW-1:0] ID_EX_RegisterRd_i,
   input  logic [REG_AW-1:0] IF_ID_RS1_i,
   input  logic [REG_AW-1:0] IF_ID_RS2_i,
   input  logic [XLEN-1:0]   Registers_RS1data_i,
   input  logic [XLEN-1:0]   Registers_RS2data_i,
   input  logic              branch_i,
   input  logic [2:0]        funct3_i,
   input  logic              mem_stall_i,
   output logic              stall_o,
   output logic              PCWrite_o,
   output logic              freeze_o,
   output logic              flush_o
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cnt_o,
   output logic [31:0]       flush_cnt_o
`endif
);

   state_e           state;
   logic [CNT_W-1:0] cnt;

   logic             hit;
   logic             load_ev;
   logic             br_ev;
   logic [CNT_W-1:0] n_req;
   logic             taken;

   // x0 is hard-wired to zero, so a write to it never creates a dependency.
   assign hit = (ID_EX_RegisterRd_i != '0) &&
                ((ID_EX_RegisterRd_i == IF_ID_RS1_i) ||
                 (ID_EX_RegisterRd_i == IF_ID_RS2_i));

   assign load_ev = ID_EX_MemRead_i & hit;
   assign br_ev   = branch_i & ID_EX_RegWrite_i & hit;
   assign n_req   = CNT_W'(stall_len(load_ev, br_ev, ID_EX_MemRead_i, LOAD_LAT));

   branch_cmp #(
      .XLEN (XLEN)
   ) u_branch_cmp (
      .rs1_data (Registers_RS1data_i),
      .rs2_data (Registers_RS2data_i),
      .funct3   (funct3_i),
      .taken    (taken)
   );

   // Reset masks every output. Freeze overrides stall and flush. In HOLD the
   // consumer is still parked in IF/ID, so events are only looked at in RUN.
   always_comb begin
      freeze_o = 1'b0;
      stall_o  = 1'b0;
      flush_o  = 1'b0;
      if (!rst_i) begin
         freeze_o = mem_stall_i;
         if (!mem_stall_i) begin
            stall_o = (state == HOLD) || load_ev || br_ev;
            flush_o = branch_i & taken & ~stall_o;
         end
      end
   end

   assign PCWrite_o = ~(stall_o | freeze_o);

   // RUN covers the first stall cycle itself, so HOLD is loaded with N-1 and
   // exits on the edge where cnt reaches 1. Frozen cycles do not count.
   // NOTE: sequential state is updated with non-blocking assignments so all
   // flops sample their inputs from the same pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= RUN;
         cnt   <= '0;
      end else if (!mem_stall_i) begin
         case (state)
            RUN: begin
               if (n_req > CNT_W'(1)) begin
                  state <= HOLD;
                  cnt   <= n_req - CNT_W'(1);
               end
            end
            HOLD: begin
               if (cnt == CNT_W'(1)) begin
                  state <= RUN;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state <= RUN;
               cnt   <= '0;
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   // Both counters stick at all-ones instead of wrapping.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_o <= '0;
         flush_cnt_o <= '0;
      end else begin
         if (stall_o && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
         end
         if (flush_o && (flush_cnt_o != '1)) begin
            flush_cnt_o <= flush_cnt_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl. Two instances share the stimulus: one with
// LOAD_LAT=1 and one with LOAD_LAT=3. Each step pushes the expected output
// vector {stall, PCWrite, freeze, flush} of both instances to a scoreboard
// queue; the entry is popped and compared on the falling edge of that cycle.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
   import hazard_pkg::*;

   localparam logic [3:0] IDLE = 4'b0100;  // no stall, PC advances
   localparam logic [3:0] STL  = 4'b1000;  // stall, PC held
   localparam logic [3:0] FRZ  = 4'b0010;  // frozen
   localparam logic [3:0] FLS  = 4'b0101;  // branch taken, flush

   typedef struct {
      string      tag;
      logic [3:0] e1;
      logic [3:0] e3;
   } exp_t;

   exp_t sb[$];

   int passed = 0;
   int total  = 0;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read;
   logic        reg_write;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        branch;
   logic [2:0]  f3;
   logic        mem_stall;

   logic stall1, pcw1, frz1, flush1;
   logic stall3, pcw3, frz3, flush3;

   always #5 clk = ~clk;

   hazard_ctrl #(.XLEN(32), .REG_AW(5), .LOAD_LAT(1), .CNT_W(3)) dut1 (
      .clk_i               (clk),
      .rst_i               (rst),
      .ID_EX_MemRead_i     (mem_read),
      .ID_EX_RegWrite_i    (reg_write),
      .ID_EX_RegisterRd_i  (rd),
      .IF_ID_RS1_i         (rs1),
      .IF_ID_RS2_i         (rs2),
      .Registers_RS1data_i (op1),
      .Registers_RS2data_i (op2),
      .branch_i            (branch),
      .funct3_i            (f3),
      .mem_stall_i         (mem_stall),
      .stall_o             (stall1),
      .PCWrite_o           (pcw1),
      .freeze_o            (frz1),
      .flush_o             (flush1)
   );

   hazard_ctrl #(.XLEN(32), .REG_AW(5), .LOAD_LAT(3), .CNT_W(3)) dut3 (
      .clk_i               (clk),
      .rst_i               (rst),
      .ID_EX_MemRead_i     (mem_read),
      .ID_EX_RegWrite_i    (reg_write),
      .ID_EX_RegisterRd_i  (rd),
      .IF_ID_RS1_i         (rs1),
      .IF_ID_RS2_i         (rs2),
      .Registers_RS1data_i (op1),
      .Registers_RS2data_i (op2),
      .branch_i            (branch),
      .funct3_i            (f3),
      .mem_stall_i         (mem_stall),
      .stall_o             (stall3),
      .PCWrite_o           (pcw3),
      .freeze_o            (frz3),
      .flush_o             (flush3)
   );

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      total++;
      assert (observed === expected) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
   endtask

   // One clock cycle with the inputs currently driven.
   task automatic cyc(input string tag, input logic [3:0] e1, input logic [3:0] e3);
      exp_t item;
      sb.push_back('{tag: tag, e1: e1, e3: e3});
      @(negedge clk);
      item = sb.pop_front();
      check({item.tag, "/lat1"}, 32'({stall1, pcw1, frz1, flush1}), 32'(item.e1));
      check({item.tag, "/lat3"}, 32'({stall3, pcw3, frz3, flush3}), 32'(item.e3));
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      mem_read  = 1'b0;
      reg_write = 1'b0;
      rd        = 5'd0;
      rs1       = 5'd0;
      rs2       = 5'd0;
      op1       = 32'd0;
      op2       = 32'd0;
      branch    = 1'b0;
      f3        = 3'b000;
      mem_stall = 1'b0;
   endtask

   task automatic load_use(input logic [4:0] r);
      mem_read  = 1'b1;
      reg_write = 1'b1;
      rd        = r;
      rs1       = r;
      rs2       = 5'd1;
   endtask

   task automatic bubble();
      mem_read  = 1'b0;
      reg_write = 1'b0;
      rd        = 5'd0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      @(posedge clk);
      #1;

      // Reset masks outputs even with a hazard and busy memory present.
      load_use(5'd5);
      mem_stall = 1'b1;
      cyc("reset", IDLE, IDLE);
      check("rst_state", 32'(dut3.state), 32'(RUN));
      check("rst_cnt", 32'(dut3.cnt), 32'd0);
      rst = 1'b0;
      idle();
      cyc("idle", IDLE, IDLE);

      // Load x5 then consumer of x5.
      load_use(5'd5);
      cyc("lu_c0", STL, STL);
      check("lu_hold_state", 32'(dut3.state), 32'(HOLD));
      check("lu_hold_cnt", 32'(dut3.cnt), 32'd2);
      bubble();
      cyc("lu_c1", IDLE, STL);
      cyc("lu_c2", IDLE, STL);
      cyc("lu_c3", IDLE, IDLE);
      check("lu_run_state", 32'(dut3.state), 32'(RUN));

      // Load to x0 with a consumer of x0.
      mem_read  = 1'b1;
      reg_write = 1'b1;
      rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
      cyc("x0", IDLE, IDLE);
      idle();

      // ALU writes x7, then BEQ x7,x7.
      reg_write = 1'b1; rd = 5'd7;
      branch = 1'b1; f3 = F3_BEQ; rs1 = 5'd7; rs2 = 5'd7;
      op1 = 32'h1234; op2 = 32'h1234;
      cyc("beq_alu_stall", STL, STL);
      bubble();
      cyc("beq_flush", FLS, FLS);

      // Condition coverage with no hazard.
      op1 = 32'hFFFF_FFFF; op2 = 32'd1;
      f3 = F3_BLT;  cyc("blt_neg", FLS, FLS);
      f3 = F3_BLTU; cyc("bltu_big", IDLE, IDLE);
      f3 = F3_BGE;  cyc("bge_neg", IDLE, IDLE);
      f3 = F3_BGEU; cyc("bgeu_big", FLS, FLS);
      f3 = F3_BNE;  cyc("bne_diff", FLS, FLS);
      f3 = 3'b010;  cyc("rsvd_010", IDLE, IDLE);
      f3 = 3'b011;  cyc("rsvd_011", IDLE, IDLE);
      op2 = 32'hFFFF_FFFF;
      f3 = F3_BNE;  cyc("bne_eq", IDLE, IDLE);
      f3 = F3_BGE;  cyc("bge_eq", FLS, FLS);
      f3 = F3_BLTU; cyc("bltu_eq", IDLE, IDLE);

      // Load to x9 feeding BEQ on rs2: N = LOAD_LAT+1 (2 and 4).
      load_use(5'd9);
      rs1 = 5'd3; rs2 = 5'd9;
      f3 = F3_BEQ; op1 = 32'd4; op2 = 32'd4;
      cyc("ldbr_c0", STL, STL);
      check("ldbr_cnt", 32'(dut3.cnt), 32'd3);
      bubble();
      cyc("ldbr_c1", STL, STL);
      cyc("ldbr_c2", FLS, STL);
      cyc("ldbr_c3", FLS, STL);
      cyc("ldbr_c4", FLS, FLS);

      // Freeze beats a taken branch.
      mem_stall = 1'b1;
      cyc("frz_branch", FRZ, FRZ);
      idle();

      // Memory busy for two cycles in the middle of HOLD.
      load_use(5'd5);
      cyc("fz_c0", STL, STL);
      bubble();
      mem_stall = 1'b1;
      cyc("fz_f0", FRZ, FRZ);
      check("fz_cnt0", 32'(dut3.cnt), 32'd2);
      cyc("fz_f1", FRZ, FRZ);
      check("fz_cnt1", 32'(dut3.cnt), 32'd2);
      check("fz_state", 32'(dut3.state), 32'(HOLD));
      mem_stall = 1'b0;
      cyc("fz_c1", IDLE, STL);
      cyc("fz_c2", IDLE, STL);
      cyc("fz_c3", IDLE, IDLE);

      // Reset pulse during HOLD.
      load_use(5'd5);
      cyc("rh_c0", STL, STL);
      bubble();
      rst = 1'b1;
      cyc("rh_rst", IDLE, IDLE);
      check("rh_state", 32'(dut3.state), 32'(RUN));
      rst = 1'b0;
      cyc("rh_after", IDLE, IDLE);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core, sitting between the IF/ID and ID/EX pipeline registers. It detects load-use and branch-operand hazards and holds the stall for a configurable number of cycles with an internal down-counter, so that multi-cycle data memory can be supported. It also freezes the whole pipeline on a data-memory busy signal and resolves all six RV32I branch conditions in ID to generate the flush. It is the parametrised successor of the single-cycle, BEQ-only hazard detection unit.

## Interface
Parameters:
- XLEN, 32, register data width.
- REG_AW, 5, register index width.
- LOAD_LAT, 1, total load-use stall cycles (≥1).
- CNT_W, 3, stall counter width; must hold LOAD_LAT+1.

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  core clock.
- rst_i  in  1  synchronous active-high reset.
- ID_EX_MemRead_i  in  1  EX-stage instruction is a load.
- ID_EX_RegWrite_i  in  1  EX-stage instruction writes rd.
- ID_EX_RegisterRd_i  in  REG_AW  EX-stage rd.
- IF_ID_RS1_i, IF_ID_RS2_i  in  REG_AW  ID-stage source indices.
- Registers_RS1data_i, Registers_RS2data_i  in  XLEN  ID-stage operands.
- branch_i  in  1  ID-stage instruction is a conditional branch.
- funct3_i  in  3  branch funct3.
- mem_stall_i  in  1  data memory busy.
- stall_o  out  1  hold IF/ID and insert an ID/EX bubble.
- PCWrite_o  out  1  PC update enable.
- freeze_o  out  1  hold all pipeline registers.
- flush_o  out  1  branch taken; flush IF/ID.

## Operation
- Hazard match (hit): rd≠0 and rd==rs1 or rd==rs2. x0 never causes a hazard.
- Load-use event: ID_EX_MemRead_i & hit. Required stall length N = LOAD_LAT.
- Branch-operand event: branch_i & ID_EX_RegWrite_i & hit.
  - N = 1 for an ALU producer.
  - N = LOAD_LAT+1 when ID_EX_MemRead_i is also set.
  - If both events apply, the larger N wins.
- States: RUN and HOLD. Counter cnt.
- RUN:
  - On an event, stall_o=1 in the same cycle (combinational).
  - If N>1, go to HOLD with cnt=N-1. Otherwise stay in RUN.
- HOLD:
  - stall_o=1 regardless of inputs. The original consumer is still in IF/ID, so no new events are evaluated.
  - cnt decrements each cycle. When cnt==1, go to RUN on the next edge.
- Freeze:
  - freeze_o = mem_stall_i, with highest priority.
  - While frozen, state and cnt hold, stall_o=0 and flush_o=0.
- PCWrite_o = ~(stall_o | freeze_o).
- Branch compare uses funct3 encodings 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU. Signed compares use $signed. Reserved encodings 010 and 011 are never taken.
- flush_o = branch_i & taken & ~stall_o & ~freeze_o. A branch never flushes on stale operands.

## Timing
- Reset values: state=RUN, cnt=0, perf counters=0.
- While rst_i=1: stall_o=0, flush_o=0, freeze_o=0, PCWrite_o=1.
- Reset during HOLD returns to RUN on the same edge; the stall drops in the following cycle.
- Detection latency is 0 cycles; the stall lasts exactly N consecutive unfrozen cycles.
- mem_stall_i during HOLD stretches the wall-clock stall but not N.
- Flush is asserted in the first unstalled cycle of the branch, combinationally.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - Adds outputs stall_cnt_o and flush_cnt_o, 32 bits each.
  - stall_cnt_o counts cycles with stall_o=1; flush_cnt_o counts cycles with flush_o=1.
  - Both saturate at 2^32-1 and clear on rst_i.
- HAZARD_PERF_CNT_EN undefined: the ports and registers do not exist.

## Structure
- hazard_pkg holds:
  - the state enum (RUN, HOLD);
  - the funct3 constants F3_BEQ..F3_BGEU;
  - a helper returning N.
- One sub-module, branch_cmp (XLEN-parametrised, combinational): takes the operands and funct3, outputs taken.

## Test plan
- Load to x5, then add using rs1=x5, LOAD_LAT=1 -> stall_o=1 and PCWrite_o=0 for exactly 1 cycle; flush_o=0.
- Same sequence with LOAD_LAT=3 -> stall_o high 3 cycles; HOLD entered with cnt=2; RUN after.
- Load to x0, then a consumer of x0 -> no stall.
- ALU writes x7, then BEQ x7,x7 -> 1 stall cycle with flush_o=0; the next cycle has flush_o=1.
- BLT with rs1=0xFFFFFFFF, rs2=1 -> flush_o=1. BLTU with the same operands -> flush_o=0.
- mem_stall_i=1 for 2 cycles mid-HOLD (LOAD_LAT=3) -> freeze_o=1, stall_o=0, cnt holds; 3 total stall cycles afterward. rst_i pulsed during HOLD -> RUN, stall_o=0 the next cycle.
